// File: rtl/cruise_ctrl_sat.sv
// cruise_ctrl_sat: cruise-control FSM with saturating speed arithmetic.
// Vehicle speed and the stored set speed are clamped to [0, MAX_SPEED];
// regulation in CRUISE steps toward the set speed without overshooting.
module cruise_ctrl_sat #(
  parameter int SPD_W      = 8,
  parameter int MIN_ENGAGE = 46,
  parameter int MAX_SPEED  = 200,
  parameter int ACC_STEP   = 1,
  parameter int COAST_STEP = 1,
  parameter int BRK_STEP   = 2,
  parameter int SET_STEP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             throttle,
  input  logic             set,
  input  logic             accel,
  input  logic             coast,
  input  logic             cancel,
  input  logic             resume,
  input  logic             brake,
  output logic [SPD_W-1:0] speed,
  output logic [SPD_W-1:0] cruisespeed,
  output logic             cruisectrl,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEL  = 3'd1,
    DECEL  = 3'd2,
    CRUISE = 3'd3,
    BRAKE  = 3'd4,
    CANCEL = 3'd5
  } state_e;

  localparam logic [SPD_W:0] MAX_V = (SPD_W+1)'(MAX_SPEED);
  localparam logic [SPD_W:0] MIN_V = (SPD_W+1)'(MIN_ENGAGE);
  localparam logic [SPD_W:0] ACC_V = (SPD_W+1)'(ACC_STEP);
  localparam logic [SPD_W:0] CST_V = (SPD_W+1)'(COAST_STEP);
  localparam logic [SPD_W:0] BRK_V = (SPD_W+1)'(BRK_STEP);
  localparam logic [SPD_W:0] SET_V = (SPD_W+1)'(SET_STEP);

  state_e           state_q;
  logic [SPD_W-1:0] speed_q, cs_q;
  logic             ctrl_q;

  // Add one extra bit of headroom, then clamp at MAX_SPEED.
  function automatic logic [SPD_W-1:0] sat_add(input logic [SPD_W-1:0] a,
                                               input logic [SPD_W:0]   b);
    logic [SPD_W:0] s;
    s = {1'b0, a} + b;
    if (s > MAX_V) s = MAX_V;
    return s[SPD_W-1:0];
  endfunction

  // Subtract with a floor of zero.
  function automatic logic [SPD_W-1:0] sat_sub(input logic [SPD_W-1:0] a,
                                               input logic [SPD_W:0]   b);
    logic [SPD_W:0] d;
    if ({1'b0, a} <= b) d = '0;
    else                d = {1'b0, a} - b;
    return d[SPD_W-1:0];
  endfunction

  logic [SPD_W-1:0] spd_acc_d, spd_cst_d, spd_brk_d, spd_reg_d, spd_decay_d;
  logic [SPD_W-1:0] cs_up_d, cs_dn_d;
  logic [SPD_W:0]   diff;
  logic             eff_brk;

  // Candidate next speeds / set speeds shared by the FSM branches.
  always_comb begin
    spd_acc_d = sat_add(speed_q, ACC_V);
    spd_cst_d = sat_sub(speed_q, CST_V);
    spd_brk_d = sat_sub(speed_q, BRK_V);
    cs_up_d   = sat_add(cs_q, SET_V);
    cs_dn_d   = sat_sub(cs_q, SET_V);
    if ({1'b0, cs_dn_d} < MIN_V) cs_dn_d = MIN_V[SPD_W-1:0];
    // Regulation moves by at most the remaining gap, so it never overshoots.
    diff      = '0;
    spd_reg_d = speed_q;
    if (speed_q > cs_q) begin
      diff      = {1'b0, speed_q} - {1'b0, cs_q};
      spd_reg_d = sat_sub(speed_q, (diff < CST_V) ? diff : CST_V);
    end else if (speed_q < cs_q) begin
      diff      = {1'b0, cs_q} - {1'b0, speed_q};
      spd_reg_d = sat_add(speed_q, (diff < ACC_V) ? diff : ACC_V);
    end
    // CANCEL behaves like BRAKE with the pedal released.
    eff_brk     = (state_q == BRAKE) && brake;
    spd_decay_d = eff_brk ? spd_brk_d : spd_cst_d;
  end

  // Main FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      speed_q <= '0;
      cs_q    <= '0;
      ctrl_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (throttle) begin
            state_q <= ACCEL;
            speed_q <= spd_acc_d;
          end
        end
        ACCEL: begin
          if (set && throttle && ({1'b0, speed_q} >= MIN_V)) begin
            state_q <= CRUISE;
            cs_q    <= speed_q;
            speed_q <= spd_acc_d;
            ctrl_q  <= 1'b1;
          end else if (!throttle) begin
            state_q <= DECEL;
            speed_q <= spd_cst_d;
          end else begin
            speed_q <= spd_acc_d;
          end
        end
        DECEL: begin
          if (throttle) begin
            state_q <= ACCEL;
            speed_q <= spd_acc_d;
          end else begin
            speed_q <= spd_cst_d;
            if (spd_cst_d == '0) state_q <= IDLE;
          end
        end
        CRUISE: begin
          if (brake) begin
            state_q <= BRAKE;
            speed_q <= spd_brk_d;
            ctrl_q  <= 1'b0;
          end else if (cancel) begin
            state_q <= CANCEL;
            speed_q <= spd_cst_d;
            ctrl_q  <= 1'b0;
          end else if (accel) begin
            cs_q    <= cs_up_d;
            speed_q <= spd_acc_d;
          end else if (coast) begin
            cs_q    <= cs_dn_d;
            speed_q <= spd_cst_d;
          end else if (throttle) begin
            speed_q <= spd_acc_d;
          end else begin
            speed_q <= spd_reg_d;
          end
        end
        BRAKE, CANCEL: begin
          if (state_q == CANCEL && brake) begin
            state_q <= BRAKE;
            speed_q <= spd_brk_d;
          end else if (resume && !eff_brk && ({1'b0, cs_q} >= MIN_V)) begin
            state_q <= CRUISE;
            ctrl_q  <= 1'b1;
          end else if (throttle && !eff_brk) begin
            state_q <= ACCEL;
            speed_q <= spd_acc_d;
          end else begin
            speed_q <= spd_decay_d;
            if (spd_decay_d == '0) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign speed       = speed_q;
  assign cruisespeed = cs_q;
  assign cruisectrl  = ctrl_q;
  assign state_o     = state_q;

endmodule
